fetch_sequencer: RTL and testbench

//  Program-counter sequencer that drives the instruction memory address and presents fetched words to decode.

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/return_addr_stack.sv | 44 ++++
 rtl/fetch_sequencer.sv | 107 ++++++++++
 tb/tb_fetch_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and default sizes for the instruction fetch sequencer.
package ifetch_pkg;
    localparam int ADDR_W_DEF    = 12;
    localparam int INSTR_W_DEF   = 19;
    localparam int RAS_DEPTH_DEF = 8;

    // Encoding 3 is reserved and behaves as JUMP.
    typedef enum logic [1:0] {
        JUMP = 2'd0,
        CALL = 2'd1,
        RET  = 2'd2
    } redir_kind_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fs_state_t;
endpackage

// File: rtl/return_addr_stack.sv
// Return-address stack: LIFO of ADDR-wide entries with full/empty flags.
// A push while full or a pop while empty is ignored; the caller flags it.
module return_addr_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int SP_W = $clog2(DEPTH) + 1;
    localparam int IX_W = SP_W - 1;

    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_m1;
    logic [W-1:0]    stack [DEPTH];

    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);
    assign sp_m1 = sp - SP_W'(1);
    assign top   = stack[sp_m1[IX_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp_m1;
        end
    end

    // Entry storage needs no reset: it is only read below a valid sp.
    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            stack[sp[IX_W-1:0]] <= push_data;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: drives instruction memory address, holds one
// fetched word for decode, and handles jump/call/return redirects and halt.
module fetch_sequencer
    import ifetch_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_instr,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready,
    input  logic               redir_valid,
    input  logic [1:0]         redir_kind,
    input  logic [ADDR_W-1:0]  redir_target,
    input  logic [ADDR_W-1:0]  redir_link,
    input  logic               halt_req,
    output logic               halted,
    output logic               ras_overflow,
    output logic               ras_underflow
);
    fs_state_t         state;
    logic [ADDR_W-1:0] pc;

    logic              run;
    logic              take_halt;
    logic              take_redir;
    logic              adv;
    logic              is_call;
    logic              is_ret;
    logic              ras_push;
    logic              ras_pop;
    logic              ras_full;
    logic              ras_empty;
    logic [ADDR_W-1:0] ras_top;

    // Handshake: the word in if_instr/if_pc transfers to decode on any edge
    // where if_valid && id_ready. While if_valid && !id_ready the register
    // and pc hold. A redirect or halt flushes the register regardless.
    assign run        = (state == RUN);
    assign take_halt  = run && halt_req;
    assign take_redir = run && !halt_req && redir_valid;
    assign adv        = run && (!if_valid || id_ready);

    assign is_call = (redir_kind == CALL);
    assign is_ret  = (redir_kind == RET);

    assign ras_push = take_redir && is_call && !ras_full;
    assign ras_pop  = take_redir && is_ret && !ras_empty;

    assign mem_addr = pc;
    assign halted   = (state == HALTED);

    return_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (redir_link),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            pc            <= '0;
            if_valid      <= 1'b0;
            if_instr      <= '0;
            if_pc         <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (take_halt) begin
            state    <= HALTED;
            if_valid <= 1'b0;
        end else if (take_redir) begin
            if_valid <= 1'b0;
            if (is_ret) begin
                if (!ras_empty) begin
                    pc <= ras_top;
                end else begin
                    pc            <= redir_target;
                    ras_underflow <= 1'b1;
                end
            end else begin
                pc <= redir_target;
                if (is_call && ras_full) begin
                    ras_overflow <= 1'b1;
                end
            end
        end else if (adv) begin
            if_instr <= mem_instr;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc + ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed + randomized bench for fetch_sequencer against a queue-based model.
module tb_fetch_sequencer;
    logic        clk;
    logic        rst;
    logic [11:0] mem_addr;
    logic [18:0] mem_instr;
    logic        if_valid;
    logic [18:0] if_instr;
    logic [11:0] if_pc;
    logic        id_ready;
    logic        redir_valid;
    logic [1:0]  redir_kind;
    logic [11:0] redir_target;
    logic [11:0] redir_link;
    logic        halt_req;
    logic        halted;
    logic        ras_overflow;
    logic        ras_underflow;

    logic [18:0] mem [0:4095];
    assign mem_instr = mem[mem_addr];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_pc;
    bit          m_valid;
    logic [18:0] m_instr;
    int          m_ifpc;
    bit          m_halted;
    bit          m_ovf;
    bit          m_udf;
    int          ras_q[$];

    fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .mem_addr      (mem_addr),
        .mem_instr     (mem_instr),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .id_ready      (id_ready),
        .redir_valid   (redir_valid),
        .redir_kind    (redir_kind),
        .redir_target  (redir_target),
        .redir_link    (redir_link),
        .halt_req      (halt_req),
        .halted        (halted),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using the current inputs.
    task automatic model_edge();
        if (rst) begin
            m_pc = 0; m_valid = 0; m_instr = '0; m_ifpc = 0;
            m_halted = 0; m_ovf = 0; m_udf = 0;
            ras_q.delete();
        end else if (m_halted) begin
            m_valid = 0;
        end else if (halt_req) begin
            m_valid  = 0;
            m_halted = 1;
        end else if (redir_valid) begin
            m_valid = 0;
            if (redir_kind == 2'd2) begin
                if (ras_q.size() > 0) m_pc = ras_q.pop_back();
                else begin
                    m_pc  = redir_target;
                    m_udf = 1;
                end
            end else begin
                m_pc = redir_target;
                if (redir_kind == 2'd1) begin
                    if (ras_q.size() < 8) ras_q.push_back(int'(redir_link));
                    else m_ovf = 1;
                end
            end
        end else if (!m_valid || id_ready) begin
            m_instr = mem[m_pc];
            m_ifpc  = m_pc;
            m_valid = 1;
            m_pc    = (m_pc + 1) % 4096;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("mem_addr", mem_addr, m_pc);
        check("if_valid", if_valid, m_valid);
        check("if_instr", if_instr, m_instr);
        check("if_pc", if_pc, m_ifpc);
        check("halted", halted, m_halted);
        check("ras_overflow", ras_overflow, m_ovf);
        check("ras_underflow", ras_underflow, m_udf);
    endtask

    task automatic redirect(input logic [1:0] kind, input logic [11:0] tgt, input logic [11:0] link);
        redir_valid  = 1'b1;
        redir_kind   = kind;
        redir_target = tgt;
        redir_link   = link;
        step();
        redir_valid = 1'b0;
    endtask

    initial begin
        logic [11:0] held_addr;
        for (int i = 0; i < 4096; i++) mem[i] = 19'($urandom);
        rst = 1'b1; id_ready = 1'b1; redir_valid = 1'b0; redir_kind = 2'd0;
        redir_target = '0; redir_link = '0; halt_req = 1'b0;

        // Reset state
        step(); step();
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_mem_addr", mem_addr, 12'd0);

        // Sequential fetch from address 0
        rst = 1'b0;
        step();
        check("first_if_pc", if_pc, 12'd0);
        check("first_if_instr", if_instr, mem[0]);
        step(); step();
        check("third_if_pc", if_pc, 12'd2);

        // Decode stall with if_pc=2
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("stall_if_pc", if_pc, 12'd2);
        check("stall_mem_addr", mem_addr, 12'd3);
        id_ready = 1'b1;
        step();
        check("resume_if_pc", if_pc, 12'd3);
        step();

        // JUMP with decode stalled flushes, then fetches target
        id_ready = 1'b0;
        redirect(2'd0, 12'h00A, 12'h000);
        check("jump_flush", if_valid, 1'b0);
        id_ready = 1'b1;
        step();
        check("jump_if_pc", if_pc, 12'h00A);

        // CALL/RET round trip
        redirect(2'd1, 12'h100, 12'h006);
        redirect(2'd2, 12'h3FF, 12'h000);
        step();
        check("ret_if_pc", if_pc, 12'h006);

        // Nine CALLs overflow an 8-deep stack, nine RETs underflow it
        for (int i = 0; i < 9; i++) redirect(2'd1, 12'h100 + 12'(i), 12'h010 + 12'(i));
        check("ovf_set", ras_overflow, 1'b1);
        for (int i = 0; i < 8; i++) redirect(2'd2, 12'h200, 12'h000);
        check("udf_clear", ras_underflow, 1'b0);
        check("pop_last", mem_addr, 12'h010);
        redirect(2'd2, 12'h200, 12'h000);
        check("udf_set", ras_underflow, 1'b1);
        step();
        check("udf_if_pc", if_pc, 12'h200);

        // PC wrap at top of memory, reserved kind behaves as JUMP
        redirect(2'd3, 12'hFFF, 12'h000);
        step();
        check("wrap_if_pc_fff", if_pc, 12'hFFF);
        step();
        check("wrap_if_pc_0", if_pc, 12'h000);

        // halt with concurrent redirect, then reset out of halt
        held_addr   = mem_addr;
        halt_req    = 1'b1;
        redir_valid = 1'b1; redir_kind = 2'd1; redir_target = 12'h123; redir_link = 12'h055;
        step();
        check("halt_halted", halted, 1'b1);
        check("halt_if_valid", if_valid, 1'b0);
        check("halt_pc", mem_addr, held_addr);
        halt_req = 1'b0;
        step(); step();
        check("halt_frozen", mem_addr, held_addr);
        redir_valid = 1'b0;
        rst = 1'b1;
        step();
        check("rst_halt_pc", mem_addr, 12'd0);
        check("rst_halt_state", halted, 1'b0);
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 4) == 0);
            halt_req     = ($urandom_range(0, 99) == 0);
            redir_valid  = ($urandom_range(0, 5) == 0);
            redir_kind   = 2'($urandom_range(0, 3));
            redir_target = 12'($urandom);
            redir_link   = 12'($urandom);
            id_ready     = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
